// File: rtl/mips_cpu_pkg.sv
// Shared MIPS core types and constants: fetch sequencer state encoding,
// default halt address and the PC block's reset vector.
package mips_cpu_pkg;

    localparam int unsigned WORD_W = 32;

    localparam logic [WORD_W-1:0] HALT_ADDR_DEFAULT = 32'h0000_0000;
    localparam logic [WORD_W-1:0] RESET_VECTOR      = 32'hBFC0_0000;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        EXEC  = 2'd1,
        HALT  = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/mips_fetch_watchdog.sv
// Fetch wait watchdog: counts consecutive waitrequest cycles and raises a sticky fault.
// Only built when MIPS_FETCH_WATCHDOG_EN is defined.
`ifdef MIPS_FETCH_WATCHDOG_EN
module mips_fetch_watchdog #(
    parameter int unsigned WDOG_LIMIT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic i_wait,
    input  logic i_accept,
    output logic o_trip_c,
    output logic o_fault
);
    localparam int unsigned CNT_W = (WDOG_LIMIT > 255) ? $clog2(WDOG_LIMIT + 1) : 8;

    logic [CNT_W-1:0] r_cnt;
    logic             r_fault;

    // Trip on the wait cycle that brings the count up to the limit.
    assign o_trip_c = i_wait && (r_cnt == CNT_W'(WDOG_LIMIT - 1));
    assign o_fault  = r_fault;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt   <= '0;
            r_fault <= 1'b0;
        end else begin
            if (i_accept) begin
                r_cnt <= '0;
            end else if (i_wait) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            if (o_trip_c) begin
                r_fault <= 1'b1;
            end
        end
    end

endmodule
`endif

// File: rtl/mips_fetch_sequencer.sv
// Multi-cycle fetch/execute sequencer: fetch handshake, PC strobes with one branch-delay slot,
// halt on redirect to HALT_ADDR. Optional fetch watchdog via MIPS_FETCH_WATCHDOG_EN.
module mips_fetch_sequencer
    import mips_cpu_pkg::*;
#(
    parameter logic [WORD_W-1:0] HALT_ADDR  = HALT_ADDR_DEFAULT,
    parameter int unsigned       WDOG_LIMIT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WORD_W-1:0] pc,
    output logic [WORD_W-1:0] instr_address,
    output logic              instr_read,
    input  logic              instr_waitrequest,
    input  logic [WORD_W-1:0] instr_readdata,
    output logic [WORD_W-1:0] instr,
    output logic              exec,
    input  logic              stall_ex,
    input  logic              branch_taken,
    input  logic [WORD_W-1:0] branch_target,
    output logic              pc_en,
    output logic              pc_load,
    output logic [WORD_W-1:0] pc_load_value,
    output logic              active,
    output logic              fault
);
    fetch_state_t      r_state;
    logic              r_delay_pending;
    logic [WORD_W-1:0] r_target;
    logic [WORD_W-1:0] r_instr;

    logic              w_fetch;
    logic              w_wait;
    logic              w_accept;
    logic              w_wdog_trip;

    assign w_fetch  = (r_state == FETCH);
    assign w_wait   = w_fetch && instr_waitrequest;
    assign w_accept = w_fetch && !instr_waitrequest;

`ifdef MIPS_FETCH_WATCHDOG_EN
    mips_fetch_watchdog #(
        .WDOG_LIMIT (WDOG_LIMIT)
    ) u_wdog (
        .clk      (clk),
        .rst      (rst),
        .i_wait   (w_wait),
        .i_accept (w_accept),
        .o_trip_c (w_wdog_trip),
        .o_fault  (fault)
    );
`else
    logic w_unused_wdog;
    assign w_unused_wdog = ^{w_wait, WDOG_LIMIT};
    assign w_wdog_trip   = 1'b0;
    assign fault         = 1'b0;
`endif

    // Request is killed by rst itself so a mid-fetch reset drops it without waiting for an edge.
    assign instr_address = pc;
    assign instr_read    = w_fetch && !rst;
    assign instr         = r_instr;
    assign exec          = (r_state == EXEC);
    assign pc_en         = exec && !stall_ex;
    assign pc_load       = pc_en && r_delay_pending;
    assign pc_load_value = r_target;
    assign active        = (r_state != HALT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state         <= FETCH;
            r_delay_pending <= 1'b0;
            r_target        <= '0;
            r_instr         <= '0;
        end else begin
            case (r_state)
                FETCH: begin
                    if (w_wdog_trip) begin
                        r_state <= HALT;
                    end else if (!instr_waitrequest) begin
                        r_instr <= instr_readdata;
                        r_state <= EXEC;
                    end
                end
                EXEC: begin
                    if (!stall_ex) begin
                        r_state <= FETCH;
                        // A pending redirect outranks any branch seen in the delay slot.
                        if (r_delay_pending) begin
                            r_delay_pending <= 1'b0;
                            if (r_target == HALT_ADDR) begin
                                r_state <= HALT;
                            end
                        end else if (branch_taken) begin
                            r_delay_pending <= 1'b1;
                            r_target        <= branch_target;
                        end
                    end
                end
                HALT: begin
                    r_state <= HALT;
                end
                default: begin
                    r_state <= FETCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mips_fetch_sequencer.sv
// Self-checking bench for mips_fetch_sequencer: directed scenarios plus a random
// instruction stream checked against an architectural delay-slot model.
module tb_mips_fetch_sequencer;
    import mips_cpu_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] pc;
    logic [31:0] instr_address;
    logic        instr_read;
    logic        instr_waitrequest = 1'b0;
    logic [31:0] instr_readdata = 32'd0;
    logic [31:0] instr;
    logic        exec;
    logic        stall_ex = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = 32'd0;
    logic        pc_en;
    logic        pc_load;
    logic [31:0] pc_load_value;
    logic        active;
    logic        fault;

    int n_tests = 0;
    int n_fail  = 0;

    // Architectural model: next PC and whether the previous instruction was an effective taken branch
    logic [31:0] m_pc;
    logic [31:0] m_last_instr;
    logic [31:0] m_prev_tgt;
    bit          m_prev_taken;
    bit          m_halted;

    mips_fetch_sequencer #(
        .HALT_ADDR  (32'h0000_0000),
        .WDOG_LIMIT (4)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .pc                (pc),
        .instr_address     (instr_address),
        .instr_read        (instr_read),
        .instr_waitrequest (instr_waitrequest),
        .instr_readdata    (instr_readdata),
        .instr             (instr),
        .exec              (exec),
        .stall_ex          (stall_ex),
        .branch_taken      (branch_taken),
        .branch_target     (branch_target),
        .pc_en             (pc_en),
        .pc_load           (pc_load),
        .pc_load_value     (pc_load_value),
        .active            (active),
        .fault             (fault)
    );

    always #5 clk = ~clk;

    // Program-counter block the sequencer drives
    always_ff @(posedge clk or posedge rst) begin
        if (rst)        pc <= RESET_VECTOR;
        else if (pc_en) pc <= pc_load ? pc_load_value : pc + 32'd4;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc         = RESET_VECTOR;
        m_last_instr = 32'd0;
        m_prev_tgt   = 32'd0;
        m_prev_taken = 1'b0;
        m_halted     = 1'b0;
    endtask

    // Assert reset for one cycle, check reset values, release at a negedge.
    task automatic do_reset();
        instr_waitrequest = 1'b0;
        stall_ex          = 1'b0;
        branch_taken      = 1'b0;
        rst               = 1'b1;
        @(negedge clk);
        #1;
        chk("rst_read_low", 32'(instr_read), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        #1;
        chk("rst_read", 32'(instr_read), 32'd1);
        chk("rst_exec", 32'(exec), 32'd0);
        chk("rst_pc_en", 32'(pc_en), 32'd0);
        chk("rst_pc_load", 32'(pc_load), 32'd0);
        chk("rst_active", 32'(active), 32'd1);
        chk("rst_fault", 32'(fault), 32'd0);
        chk("rst_instr", instr, 32'd0);
        chk("rst_addr", instr_address, RESET_VECTOR);
    endtask

    // One instruction: `waits` waitrequest cycles, accept, then `stalls` stall cycles and a final EXEC cycle.
    task automatic run_instr(input int waits, input int stalls, input bit br, input logic [31:0] tgt);
        logic [31:0] data;
        bit          redirect;
        data     = $urandom;
        redirect = m_prev_taken;
        for (int w = 0; w <= waits; w++) begin
            instr_waitrequest = (w < waits);
            instr_readdata    = (w < waits) ? ~data : data;
            stall_ex          = 1'b0;
            branch_taken      = 1'($urandom_range(0, 1));
            branch_target     = $urandom;
            #1;
            chk("fetch_read", 32'(instr_read), 32'd1);
            chk("fetch_addr", instr_address, m_pc);
            chk("fetch_exec", 32'(exec), 32'd0);
            chk("fetch_pc_en", 32'(pc_en), 32'd0);
            chk("fetch_active", 32'(active), 32'd1);
            chk("instr_hold", instr, m_last_instr);
            @(negedge clk);
        end
        m_last_instr = data;
        for (int s = 0; s <= stalls; s++) begin
            instr_waitrequest = 1'($urandom_range(0, 1));
            instr_readdata    = $urandom;
            stall_ex          = (s < stalls);
            branch_taken      = (s < stalls) ? 1'($urandom_range(0, 1)) : br;
            branch_target     = (s < stalls) ? 32'($urandom) : tgt;
            #1;
            chk("exec_flag", 32'(exec), 32'd1);
            chk("exec_read", 32'(instr_read), 32'd0);
            chk("exec_instr", instr, data);
            chk("exec_pc_en", 32'(pc_en), 32'(s == stalls));
            chk("exec_pc_load", 32'(pc_load), 32'((s == stalls) && redirect));
            if ((s == stalls) && redirect) chk("pc_load_value", pc_load_value, m_prev_tgt);
            @(negedge clk);
        end
        if (redirect) begin
            m_halted     = (m_prev_tgt == 32'h0000_0000);
            m_pc         = m_prev_tgt;
            m_prev_taken = 1'b0;
        end else begin
            m_pc         = m_pc + 32'd4;
            m_prev_taken = br;
            m_prev_tgt   = tgt;
        end
    endtask

    task automatic check_halted(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            instr_waitrequest = 1'($urandom_range(0, 1));
            stall_ex          = 1'($urandom_range(0, 1));
            branch_taken      = 1'($urandom_range(0, 1));
            #1;
            chk("halt_active", 32'(active), 32'd0);
            chk("halt_read", 32'(instr_read), 32'd0);
            chk("halt_exec", 32'(exec), 32'd0);
            chk("halt_pc_en", 32'(pc_en), 32'd0);
            @(negedge clk);
        end
    endtask

    initial begin
        model_reset();
        do_reset();

        // Zero-wait fetch, three-wait fetch, branch with delay slot, stalled execute
        run_instr(0, 0, 1'b0, 32'd0);
        run_instr(3, 0, 1'b0, 32'd0);
        run_instr(0, 0, 1'b1, 32'hBFC0_0100);
        run_instr(1, 0, 1'b1, 32'hBFC0_0800);
        chk("redirect_pc", m_pc, 32'hBFC0_0100);
        run_instr(0, 4, 1'b0, 32'd0);
        run_instr(0, 0, 1'b0, 32'd0);

        // Reset in the middle of a waiting delay-slot fetch
        run_instr(0, 0, 1'b1, 32'hBFC0_0200);
        instr_waitrequest = 1'b1;
        #1;
        chk("midrst_read_before", 32'(instr_read), 32'd1);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_read_drop", 32'(instr_read), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        run_instr(0, 0, 1'b0, 32'd0);
        run_instr(0, 0, 1'b0, 32'd0);

        // Random instruction stream, targets never the halt address
        for (int k = 0; k < 40; k++) begin
            logic [31:0] tgt;
            tgt = 32'hBFC0_0000 | (32'($urandom) & 32'h000F_FFFC);
            run_instr($urandom_range(0, 2), $urandom_range(0, 3), ($urandom_range(0, 9) < 4), tgt);
        end

        // Memory stuck in waitrequest
        do_reset();
        for (int i = 0; i < 4; i++) begin
            instr_waitrequest = 1'b1;
            #1;
            chk("stuck_read", 32'(instr_read), 32'd1);
            chk("stuck_fault_early", 32'(fault), 32'd0);
            @(negedge clk);
        end
        #1;
`ifdef MIPS_FETCH_WATCHDOG_EN
        chk("wdog_fault", 32'(fault), 32'd1);
        chk("wdog_active", 32'(active), 32'd0);
        chk("wdog_read", 32'(instr_read), 32'd0);
`else
        chk("nowdog_fault", 32'(fault), 32'd0);
        chk("nowdog_active", 32'(active), 32'd1);
        chk("nowdog_read", 32'(instr_read), 32'd1);
`endif

        // Branch to address 0: delay slot runs, then the core parks
        do_reset();
        run_instr(0, 0, 1'b0, 32'd0);
        run_instr(0, 1, 1'b1, 32'h0000_0000);
        run_instr(1, 1, 1'b1, 32'hBFC0_0040);
        chk("model_halted", 32'(m_halted), 32'd1);
        check_halted(5);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
